cg_ctrl: RTL and testbench
==========================

CG_CTRL -- requirements
Module: cg_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 16, giving the number of consecutive idle cycles before gating (legal range 1..255).
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 2, giving the settle cycles between enable re-assertion and RUN (legal range 1..15).
REQ-003 The block SHALL have parameter EVT_W, default 16, giving the width of the gating-event counter.
REQ-004 Port list, in this order:
- clk  in  1  single clock; all logic posedge.
- rst_n  in  1  synchronous, active-low reset.
- act  in  1  activity indication from the gated domain; 1 = busy this cycle.
- force_on  in  1  level; 1 = never gate.
- wake_req  in  1  wake request; held high until wake_ack.
- wake_ack  out  1  one-cycle pulse; the gated clock is running and settled.
- cg_en  out  1  registered enable to the integrated clock-gate cell; 1 = clock runs.
- state  out  2  current FSM state encoding.
- gate_events  out  EVT_W  saturating count of RUN->GATED transitions.

Function
REQ-005 The FSM SHALL have states RUN=2'd0, GATED=2'd1, WAKE=2'd2; 2'd3 is illegal and SHALL return to RUN on the next cycle with cg_en=1.
REQ-006 cg_en SHALL be a flop output: 1 in RUN and WAKE, 0 in GATED, and it SHALL change on the same edge as the state register.
REQ-007 In RUN, an idle counter (8 bits) SHALL increment each cycle in which act=0, wake_req=0 and force_on=0, and SHALL clear to 0 in any other cycle.
REQ-008 RUN->GATED SHALL occur on the edge at which the idle counter would reach IDLE_CYCLES; with IDLE_CYCLES=16, cg_en falls 16 edges after the last active cycle.
REQ-009 In GATED, act=1, wake_req=1 or force_on=1 SHALL move the FSM to WAKE on the next edge, raising cg_en at that edge.
REQ-010 In WAKE, a settle counter SHALL count WAKE_CYCLES edges, then move the FSM to RUN with the idle counter cleared; act is ignored in WAKE.
REQ-011 When a wake_req is pending at the WAKE->RUN transition, wake_ack SHALL pulse high for exactly the first RUN cycle.
REQ-012 A wake_req seen in RUN SHALL produce wake_ack on the next cycle, and the block SHALL NOT issue a second wake_ack while wake_req stays high after the ack; a new request requires wake_req low for at least one cycle.
REQ-013 gate_events SHALL increment by 1 on each RUN->GATED transition and SHALL saturate at all-ones without wrapping.
REQ-014 If force_on=1 and the idle limit is reached on the same cycle, force_on SHALL win and the FSM SHALL stay in RUN.

Reset
REQ-015 On a clk edge with rst_n=0, the block SHALL set: state=RUN, cg_en=1, wake_ack=0, gate_events=0, idle and settle counters=0.
REQ-016 Reset asserted in any state, including GATED mid-operation, SHALL take effect on that edge; the clock therefore resumes one edge after reset.

Structure
REQ-017 The state encodings and the idle and settle counter widths SHALL be declared in the shared package cg_pkg.
REQ-018 The block SHALL be a single module without sub-modules; the gating cell itself SHALL stay external, driven by cg_en.

Verification
REQ-019 Idle entry: after reset, hold act=0 for 20 cycles -> cg_en=0 exactly 16 edges after reset deassertion, state=GATED, gate_events=1.
REQ-020 Activity wake: in GATED, drive act=1 for one cycle -> cg_en=1 on the next edge, state=WAKE for 2 cycles, then RUN, and wake_ack stays 0.
REQ-021 Request handshake: in GATED, raise wake_req -> wake_ack is a single pulse 3 edges later (1 to WAKE plus 2 settle), and no further pulse occurs while wake_req is held.
REQ-022 force_on: hold force_on=1 with act=0 for 100 cycles -> cg_en stays 1 and gate_events=0.
REQ-023 Reset in GATED: assert rst_n=0 for one edge while gated -> cg_en=1 and state=RUN on that edge, and gate_events=0.
REQ-024 Saturation: with EVT_W=2, run 5 gate/wake cycles -> gate_events=3 and holds at 3.

Source files
------------

// File: rtl/cg_pkg.sv
// Shared definitions for the clock-gate controller: FSM encodings and counter widths.
package cg_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_GATED   = 2'd1,
    ST_WAKE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } cg_state_e;

  localparam int IDLE_CNT_W   = 8;
  localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/cg_ctrl.sv
// Idle-driven clock-gate controller: gates after a run of idle cycles, wakes on
// activity/force/request, and acknowledges wake requests once the clock has settled.
module cg_ctrl
  import cg_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int EVT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act,
  input  logic             force_on,
  input  logic             wake_req,
  output logic             wake_ack,
  output logic             cg_en,
  output logic [1:0]       state,
  output logic [EVT_W-1:0] gate_events
);

  localparam logic [IDLE_CNT_W-1:0]   IDLE_LIMIT  = IDLE_CNT_W'(IDLE_CYCLES);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(WAKE_CYCLES - 1);

  cg_state_e               state_q, state_d;
  logic [IDLE_CNT_W-1:0]   idle_q, idle_d, idle_inc;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic [EVT_W-1:0]        evt_q, evt_d;
  logic                    cg_en_q, cg_en_d;
  logic                    wake_ack_q, wake_ack_d;
  logic                    acked_q, acked_d;
  logic                    idle_cycle;

  assign idle_cycle = !act && !wake_req && !force_on;
  assign idle_inc   = idle_q + IDLE_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      idle_q     <= '0;
      settle_q   <= '0;
      evt_q      <= '0;
      cg_en_q    <= 1'b1;
      wake_ack_q <= 1'b0;
      acked_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      settle_q   <= settle_d;
      evt_q      <= evt_d;
      cg_en_q    <= cg_en_d;
      wake_ack_q <= wake_ack_d;
      acked_q    <= acked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    settle_d   = settle_q;
    evt_d      = evt_q;
    wake_ack_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        wake_ack_d = wake_req && !acked_q;
        if (!idle_cycle) begin
          idle_d = '0;
        end else if (idle_inc == IDLE_LIMIT) begin
          state_d = ST_GATED;
          idle_d  = '0;
          if (evt_q != '1) evt_d = evt_q + EVT_W'(1);
        end else begin
          idle_d = idle_inc;
        end
      end
      ST_GATED: begin
        if (act || wake_req || force_on) begin
          state_d  = ST_WAKE;
          settle_d = '0;
        end
      end
      ST_WAKE: begin
        // act is deliberately ignored here; only the settle count matters
        if (settle_q == SETTLE_LAST) begin
          state_d    = ST_RUN;
          settle_d   = '0;
          idle_d     = '0;
          wake_ack_d = wake_req && !acked_q;
        end else begin
          settle_d = settle_q + SETTLE_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        idle_d   = '0;
        settle_d = '0;
      end
    endcase
    // A request stays acknowledged until wake_req drops, blocking a second pulse
    acked_d = wake_req && (acked_q || wake_ack_d);
    cg_en_d = (state_d != ST_GATED);
  end

  assign wake_ack    = wake_ack_q;
  assign cg_en       = cg_en_q;
  assign state       = state_q;
  assign gate_events = evt_q;

endmodule

// File: tb/tb_cg_ctrl.sv
// Directed self-checking bench for cg_ctrl; a second instance with EVT_W=2 covers saturation.
module tb_cg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act = 1'b0;
  logic       force_on = 1'b0;
  logic       wake_req = 1'b0;
  logic       wake_ack, cg_en;
  logic [1:0] state;
  logic [15:0] gate_events;
  logic       wake_ack_s, cg_en_s;
  logic [1:0] state_s;
  logic [1:0] gate_events_s;

  int compared = 0;
  int mismatched = 0;

  cg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .act(act), .force_on(force_on), .wake_req(wake_req),
    .wake_ack(wake_ack), .cg_en(cg_en), .state(state), .gate_events(gate_events)
  );

  cg_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .EVT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .act(act), .force_on(force_on), .wake_req(wake_req),
    .wake_ack(wake_ack_s), .cg_en(cg_en_s), .state(state_s), .gate_events(gate_events_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    act = 1'b0; force_on = 1'b0; wake_req = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    act = 1'b1; force_on = 1'b0; wake_req = 1'b1;
    rst_n = 1'b0;
    step(2);
    if (state !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    compared++;
    if (cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cg_en: got %b expected 1", cg_en); end
    compared++;
    if (wake_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wake_ack: got %b expected 0", wake_ack); end
    compared++;
    if (gate_events !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_events: got %0d expected 0", gate_events); end
    compared++;
  endtask

  task automatic test_idle_entry();
    doReset();
    step(15);
    if (cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_15_cg_en: got %b expected 1", cg_en); end
    compared++;
    step(1);
    if (cg_en !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_16_cg_en: got %b expected 0", cg_en); end
    compared++;
    if (state !== 2'd1) begin mismatched++; $display("[TB] FAIL idle_16_state: got %0d expected 1", state); end
    compared++;
    step(4);
    if (state !== 2'd1 || cg_en !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_hold: state %0d cg_en %b expected 1/0", state, cg_en); end
    compared++;
    if (gate_events !== 16'd1) begin mismatched++; $display("[TB] FAIL idle_events: got %0d expected 1", gate_events); end
    compared++;
  endtask

  task automatic test_act_wake();
    int ackSeen = 0;
    act = 1'b1;
    step(1);
    act = 1'b0;
    if (cg_en !== 1'b1 || state !== 2'd2) begin mismatched++; $display("[TB] FAIL act_wake_enter: cg_en %b state %0d expected 1/2", cg_en, state); end
    compared++;
    ackSeen += wake_ack;
    step(1);
    if (state !== 2'd2) begin mismatched++; $display("[TB] FAIL act_wake_settle: got %0d expected 2", state); end
    compared++;
    ackSeen += wake_ack;
    step(1);
    if (state !== 2'd0 || cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL act_wake_run: state %0d cg_en %b expected 0/1", state, cg_en); end
    compared++;
    ackSeen += wake_ack;
    step(1);
    ackSeen += wake_ack;
    if (ackSeen !== 0) begin mismatched++; $display("[TB] FAIL act_wake_no_ack: got %0d pulses expected 0", ackSeen); end
    compared++;
    // idle count restarted on WAKE->RUN: 16 edges from that edge, 1 already elapsed
    step(14);
    if (cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL regate_early: got %b expected 1", cg_en); end
    compared++;
    step(1);
    if (cg_en !== 1'b0 || gate_events !== 16'd2) begin mismatched++; $display("[TB] FAIL regate: cg_en %b events %0d expected 0/2", cg_en, gate_events); end
    compared++;
  endtask

  task automatic test_wake_req();
    int ackSeen = 0;
    wake_req = 1'b1;
    step(1);
    if (state !== 2'd2 || wake_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL req_edge1: state %0d ack %b expected 2/0", state, wake_ack); end
    compared++;
    step(1);
    if (wake_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL req_edge2: got %b expected 0", wake_ack); end
    compared++;
    step(1);
    if (wake_ack !== 1'b1 || state !== 2'd0) begin mismatched++; $display("[TB] FAIL req_ack: ack %b state %0d expected 1/0", wake_ack, state); end
    compared++;
    for (int i = 0; i < 6; i++) begin
      step(1);
      ackSeen += wake_ack;
    end
    if (ackSeen !== 0) begin mismatched++; $display("[TB] FAIL req_held_no_reack: got %0d pulses expected 0", ackSeen); end
    compared++;
    wake_req = 1'b0;
    step(1);
    wake_req = 1'b1;
    step(1);
    if (wake_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL req_in_run_ack: got %b expected 1", wake_ack); end
    compared++;
    step(1);
    if (wake_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL req_in_run_single: got %b expected 0", wake_ack); end
    compared++;
    wake_req = 1'b0;
  endtask

  task automatic test_force_on();
    int lowSeen = 0;
    doReset();
    force_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (cg_en !== 1'b1) lowSeen++;
    end
    if (lowSeen !== 0) begin mismatched++; $display("[TB] FAIL force_on_cg_en: got %0d gated cycles expected 0", lowSeen); end
    compared++;
    if (gate_events !== 16'd0) begin mismatched++; $display("[TB] FAIL force_on_events: got %0d expected 0", gate_events); end
    compared++;
    // force_on arriving on the limit cycle must keep RUN
    doReset();
    step(15);
    force_on = 1'b1;
    step(1);
    force_on = 1'b0;
    if (state !== 2'd0 || cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL force_on_limit: state %0d cg_en %b expected 0/1", state, cg_en); end
    compared++;
    step(15);
    if (cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL force_on_recount: got %b expected 1", cg_en); end
    compared++;
    step(1);
    if (cg_en !== 1'b0) begin mismatched++; $display("[TB] FAIL force_on_regate: got %b expected 0", cg_en); end
    compared++;
    force_on = 1'b1;
    step(1);
    if (state !== 2'd2 || cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL force_wake: state %0d cg_en %b expected 2/1", state, cg_en); end
    compared++;
    force_on = 1'b0;
  endtask

  task automatic test_reset_gated();
    doReset();
    step(16);
    if (state !== 2'd1) begin mismatched++; $display("[TB] FAIL rst_gated_pre: got %0d expected 1", state); end
    compared++;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    if (state !== 2'd0 || cg_en !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_gated: state %0d cg_en %b expected 0/1", state, cg_en); end
    compared++;
    if (gate_events !== 16'd0) begin mismatched++; $display("[TB] FAIL rst_gated_events: got %0d expected 0", gate_events); end
    compared++;
  endtask

  task automatic test_saturation();
    logic [1:0] expSat;
    doReset();
    for (int n = 1; n <= 5; n++) begin
      step(16);
      expSat = (n > 3) ? 2'd3 : 2'(n);
      if (gate_events_s !== expSat) begin mismatched++; $display("[TB] FAIL sat_events_%0d: got %0d expected %0d", n, gate_events_s, expSat); end
      compared++;
      if (gate_events !== 16'(n)) begin mismatched++; $display("[TB] FAIL wide_events_%0d: got %0d expected %0d", n, gate_events, n); end
      compared++;
      act = 1'b1;
      step(1);
      act = 1'b0;
      step(2);
    end
    step(16);
    if (gate_events_s !== 2'd3 || state_s !== 2'd1) begin mismatched++; $display("[TB] FAIL sat_hold: events %0d state %0d expected 3/1", gate_events_s, state_s); end
    compared++;
  endtask

  initial begin
    test_reset();
    test_idle_entry();
    test_act_wake();
    test_wake_req();
    test_force_on();
    test_reset_gated();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
